// File: rtl/bloom_filter_pkg.sv
// Shared definitions for the Bloom-filter insert engine.
//   - default key / address / probe-count parameters
//   - FSM state encoding
//   - per-probe rotation amounts and the XOR-fold hash function
package bloom_filter_pkg;

  localparam int DEF_KEY_W  = 72;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_K      = 3;

  // Rotation amount applied to the key before folding, one per probe.
  localparam int NUM_ROT = 3;
  localparam int ROT [NUM_ROT] = '{0, 23, 47};

  // Key is zero-extended at the MSB end to a whole number of address slices.
  localparam int FOLD_W     = ((DEF_KEY_W + DEF_ADDR_W - 1) / DEF_ADDR_W) * DEF_ADDR_W;
  localparam int NUM_SLICES = FOLD_W / DEF_ADDR_W;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_HASH,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Rotate left by rot within the key width, zero-extend, XOR all slices.
  // Sized for the default key and address widths.
  function automatic logic [DEF_ADDR_W-1:0] fold_hash(
    input logic [DEF_KEY_W-1:0] key,
    input int                   rot
  );
    logic [DEF_KEY_W-1:0]  rotated;
    logic [FOLD_W-1:0]     extended;
    logic [DEF_ADDR_W-1:0] folded;
    if (rot == 0) begin
      rotated = key;
    end else begin
      rotated = (key << rot) | (key >> (DEF_KEY_W - rot));
    end
    extended = FOLD_W'(rotated);
    folded   = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      folded = folded ^ DEF_ADDR_W'(extended >> (s * DEF_ADDR_W));
    end
    return folded;
  endfunction

endpackage

// File: rtl/bloom_filter_bram_ram.sv
// 1-bit wide, 2^ADDR_W deep single-port synchronous RAM (read-first),
// written so that it maps onto a block RAM. Contents are never reset.
//   clk  : clock
//   en   : port enable (read and/or write)
//   we   : write enable
//   addr : bit address
//   din  : write data
//   dout : registered read data, valid one cycle after en
module bloom_bit_ram
  import bloom_filter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              din,
  output logic              dout
);

  logic mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/bloom_filter_bram.sv
// Bloom-filter insert engine. Each accepted key is hashed K ways; every
// probed bit is read, ANDed into a membership accumulator and then set.
// After the last probe, done pulses for one cycle with present = 1 iff
// every probed bit was already set.
//   clka    : clock (rising edge)
//   rst_n   : asynchronous active-low reset; restarts the RAM clear sweep
//   data_in : key, captured when start is accepted
//   start   : request pulse
//   done    : one-cycle completion pulse
//   present : membership result, valid while done = 1
module bloom_filter_bram
  import bloom_filter_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int K      = DEF_K
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] data_in,
  input  logic             start,
  output logic             done,
  output logic             present
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  state_t             state_reg;
  logic [ADDR_W-1:0]  clear_cnt_reg;
  logic               pending_reg;
  logic [KEY_W-1:0]   key_reg;
  logic [ADDR_W-1:0]  hash_reg  [K];
  logic [ADDR_W-1:0]  hash_next [K];
  logic [IDX_W-1:0]   idx_reg;
  logic               acc_reg;
  logic               done_reg;
  logic               present_reg;

  logic               ram_en;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_din;
  logic               ram_dout;

  // One combinational hash per probe, computed from the captured key.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_hash
      assign hash_next[gi] = fold_hash(key_reg, ROT[gi % NUM_ROT]);
    end
  endgenerate

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_CLEAR;
      clear_cnt_reg <= '0;
      pending_reg   <= 1'b0;
      key_reg       <= '0;
      idx_reg       <= '0;
      acc_reg       <= 1'b0;
      done_reg      <= 1'b0;
      present_reg   <= 1'b0;
      for (int j = 0; j < K; j++) begin
        hash_reg[j] <= '0;
      end
    end else begin
      done_reg    <= 1'b0;
      present_reg <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          clear_cnt_reg <= clear_cnt_reg + 1'b1;
          if (start && !pending_reg) begin
            key_reg <= data_in;
          end
          if (clear_cnt_reg == '1) begin
            // A request latched during the sweep (or arriving on its last
            // edge) is served as if it had been sampled while idle.
            pending_reg <= 1'b0;
            idx_reg     <= '0;
            state_reg   <= (pending_reg || start) ? ST_HASH : ST_IDLE;
          end else if (start) begin
            pending_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (start) begin
            key_reg   <= data_in;
            idx_reg   <= '0;
            state_reg <= ST_HASH;
          end
        end
        ST_HASH: begin
          for (int j = 0; j < K; j++) begin
            hash_reg[j] <= hash_next[j];
          end
          acc_reg   <= 1'b1;
          state_reg <= ST_READ;
        end
        ST_READ: begin
          state_reg <= ST_CHECK;
        end
        ST_CHECK: begin
          acc_reg <= acc_reg & ram_dout;
          if (idx_reg == IDX_W'(K - 1)) begin
            done_reg    <= 1'b1;
            present_reg <= acc_reg & ram_dout;
            state_reg   <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= ST_READ;
          end
        end
        ST_DONE: begin
          // A start coinciding with the falling edge of done is taken
          // directly, giving one key every 2K+2 cycles.
          if (start) begin
            key_reg   <= data_in;
            idx_reg   <= '0;
            state_reg <= ST_HASH;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  // RAM port: the sweep writes zeros; READ reads the probe bit; CHECK sets
  // it, so a duplicate address in a later probe already reads back 1.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = hash_reg[idx_reg];
    ram_din  = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clear_cnt_reg;
      end
      ST_READ: begin
        ram_en = 1'b1;
      end
      ST_CHECK: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        ram_din = 1'b1;
      end
      default: ;
    endcase
  end

  bloom_bit_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clka),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign done    = done_reg;
  assign present = present_reg;

endmodule

// File: tb/tb_bloom_filter_bram.sv
// Testbench for bloom_filter_bram: scenario tasks drive keys and check
// latency inline; a scoreboard queue holds the expected present value of
// every accepted request and is popped whenever done pulses.
module tb_bloom_filter_bram;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [71:0] data_in = '0;
  logic        done;
  logic        present;

  typedef struct {
    logic [71:0] key;
    bit          exp;
  } txn_t;

  txn_t exp_q [$];
  txn_t mon_t;
  bit   model [1024];
  int   rot_tb [3] = '{0, 23, 47};
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;

  bloom_filter_bram dut (
    .clka    (clka),
    .rst_n   (rst_n),
    .data_in (data_in),
    .start   (start),
    .done    (done),
    .present (present)
  );

  always #5 clka = ~clka;

  // Independent hash: each key bit lands at position (b+rot) mod 72 of the
  // rotated key, which folds onto address bit ((b+rot) mod 72) mod 10.
  function automatic logic [9:0] tb_hash(input logic [71:0] key, input int rot);
    logic [9:0] h;
    h = '0;
    for (int b = 0; b < 72; b++) begin
      if (key[b]) h = h ^ (10'd1 << (((b + rot) % 72) % 10));
    end
    return h;
  endfunction

  function automatic bit model_insert(input logic [71:0] key);
    bit all_set;
    logic [9:0] a;
    all_set = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = tb_hash(key, rot_tb[i]);
      all_set = all_set & model[a];
      model[a] = 1'b1;
    end
    return all_set;
  endfunction

  task automatic push_exp(input logic [71:0] key, input bit use_const, input bit const_exp);
    bit m;
    txn_t t;
    m = model_insert(key);
    t.key = key;
    t.exp = use_const ? const_exp : m;
    exp_q.push_back(t);
  endtask

  task automatic model_clear();
    for (int a = 0; a < 1024; a++) model[a] = 1'b0;
  endtask

  // Caller sits at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [71:0] key);
    start   = 1'b1;
    data_in = key;
    @(posedge clka);
    @(negedge clka);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clka);
      @(negedge clka);
      cyc++;
    end while (!done && cyc < budget);
  endtask

  // Scoreboard: one expected entry per done pulse.
  always @(negedge clka) begin
    if (rst_n && done) begin
      done_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no request outstanding, required done=0");
      end else begin
        mon_t = exp_q.pop_front();
        if (present !== mon_t.exp) begin
          errors++;
          $display("FAIL present key=%h: got %0b, required %0b", mon_t.key, present, mon_t.exp);
        end else begin
          $display("txn key=%h present=%0b expected=%0b", mon_t.key, present, mon_t.exp);
        end
      end
    end
  end

  task automatic sweep_with_pending(input logic [71:0] key, input bit exp, input string name);
    int cyc;
    rst_n   = 1'b1;
    start   = 1'b1;
    data_in = key;
    push_exp(key, 1'b1, exp);
    @(posedge clka);
    @(negedge clka);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1100) begin
      @(posedge clka);
      @(negedge clka);
      cyc++;
    end
    checks++;
    if (cyc !== 1031 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: done seen after %0d cycles (done=%0b), required 1031", name, cyc, done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clka);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %0b, required 0", done);
    end
    checks++;
    if (present !== 1'b0) begin
      errors++;
      $display("FAIL reset_present: got %0b, required 0", present);
    end
    // start on the very first edge after release must survive the sweep
    sweep_with_pending(72'h0, 1'b0, "pending_after_reset");
  endtask

  task automatic test_repeat_zero();
    int cyc;
    push_exp(72'h0, 1'b1, 1'b1);
    issue(72'h0);
    wait_done(20, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, required 7", cyc);
    end
    @(posedge clka);
    @(negedge clka);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done still %0b one cycle later, required 0", done);
    end
  endtask

  task automatic test_key_patterns();
    logic [71:0] keys [4];
    bit          exps [4];
    int          cyc;
    keys = '{72'h1, 72'h1, {72{1'b1}}, {72{1'b1}}};
    exps = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 4; n++) begin
      push_exp(keys[n], 1'b1, exps[n]);
      issue(keys[n]);
      wait_done(20, cyc);
      checks++;
      if (cyc !== 7) begin
        errors++;
        $display("FAIL pattern_latency[%0d]: got %0d cycles, required 7", n, cyc);
      end
      @(negedge clka);
    end
  endtask

  task automatic test_random_keys();
    logic [71:0] key;
    int          cyc;
    for (int n = 0; n < 6; n++) begin
      key = 72'({$urandom(), $urandom(), $urandom()});
      for (int r = 0; r < 2; r++) begin
        push_exp(key, 1'b0, 1'b0);
        issue(key);
        wait_done(20, cyc);
        checks++;
        if (cyc !== 7) begin
          errors++;
          $display("FAIL random_latency[%0d.%0d]: got %0d cycles, required 7", n, r, cyc);
        end
        @(negedge clka);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [71:0] ka;
    logic [71:0] kb;
    int          cyc;
    int          d0;
    ka = 72'h12_3456_789A_BCDE_F012;
    kb = 72'hA5_5A5A_C3C3_0F0F_9669;
    d0 = done_count;
    push_exp(ka, 1'b0, 1'b0);
    issue(ka);
    // hold start with another key through HASH/READ/CHECK/READ/CHECK
    start   = 1'b1;
    data_in = kb;
    cyc = 0;
    do begin
      @(posedge clka);
      @(negedge clka);
      cyc++;
      if (cyc >= 5) start = 1'b0;
    end while (!done && cyc < 20);
    start = 1'b0;
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL ignored_latency: got %0d cycles, required 7", cyc);
    end
    repeat (12) @(negedge clka);
    checks++;
    if (done_count - d0 !== 1) begin
      errors++;
      $display("FAIL ignored_done_count: got %0d done pulses, required 1", done_count - d0);
    end
    // the ignored key must not have been recorded
    push_exp(kb, 1'b0, 1'b0);
    issue(kb);
    wait_done(20, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL ignored_key_latency: got %0d cycles, required 7", cyc);
    end
    @(negedge clka);
  endtask

  task automatic test_back_to_back();
    logic [71:0] ka;
    logic [71:0] kb;
    int          cyc;
    ka = 72'h00_0000_0000_00FF_00FF;
    kb = 72'hFF_00FF_0000_0000_0000;
    push_exp(ka, 1'b0, 1'b0);
    issue(ka);
    wait_done(20, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d cycles, required 7", cyc);
    end
    // sampled on the edge where done falls
    push_exp(kb, 1'b0, 1'b0);
    issue(kb);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_fall: got %0b, required 0", done);
    end
    wait_done(20, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d cycles, required 7", cyc);
    end
    @(negedge clka);
  endtask

  task automatic test_reset_mid();
    logic [71:0] k;
    int          cyc;
    k = 72'h1;
    // re-insert key 1 so present is high while done is high
    push_exp(k, 1'b1, 1'b1);
    issue(k);
    wait_done(20, cyc);
    checks++;
    if (cyc !== 7 || done !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: done after %0d cycles (done=%0b), required 7", cyc, done);
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_done: got %0b, required 0", done);
    end
    checks++;
    if (present !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_present: got %0b, required 0", present);
    end
    @(negedge clka);
    @(negedge clka);
    // after the new sweep key 1 is gone again
    sweep_with_pending(k, 1'b0, "post_reset_key1");
    @(negedge clka);
  endtask

  initial begin
    test_reset();
    test_repeat_zero();
    test_key_patterns();
    test_random_keys();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clka);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL outstanding: got %0d requests without done, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
